// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: opcodes, state codes,
// datapath mux selects and the packed control word handed from decode to the top level.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_ADDI  = 6'd8;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [3:0] S_ADDIEX = 4'd10;
    localparam logic [3:0] S_ADDIWB = 4'd11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       branch_ne;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUOp;
        logic [1:0] PCSource;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: is_supported = 1'b1;
            default:                                              is_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control sequencer (master) and the MIPS datapath (slave).
interface multicycle_control_if #(parameter int RETIRED_W = 32) ();

    logic [5:0]           opcode;
    logic                 Zero;
    logic                 mem_ready;
    logic                 PCWrite;
    logic                 pc_en;
    logic                 IorD;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 IRWrite;
    logic                 MemtoReg;
    logic                 RegDst;
    logic                 RegWrite;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic [1:0]           PCSource;
    logic                 illegal_op;
    logic [3:0]           state_dbg;
    logic [RETIRED_W-1:0] retired;

    modport master (
        input  opcode, Zero, mem_ready,
        output PCWrite, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state_dbg, retired
    );

    modport slave (
        output opcode, Zero, mem_ready,
        input  PCWrite, pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state_dbg, retired
    );

endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decode; everything not listed for a state stays 0.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.MemRead  = 1'b1;
                o_ctrl.ALUSrcB  = SRCB_FOUR;
                o_ctrl.IRWrite  = i_mem_ready;
                o_ctrl.PCWrite  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.ALUSrcB    = SRCB_SEXT_SH;
                o_ctrl.illegal_op = ~is_supported(i_opcode);
            end
            S_MEMADR: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = SRCB_SEXT;
            end
            S_MEMRD: begin
                o_ctrl.MemRead = 1'b1;
                o_ctrl.IorD    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.MemWrite = 1'b1;
                o_ctrl.IorD     = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUOp   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                o_ctrl.RegWrite = 1'b1;
                o_ctrl.RegDst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.ALUSrcA     = 1'b1;
                o_ctrl.ALUOp       = ALUOP_SUB;
                o_ctrl.PCSource    = PCSRC_ALUOUT;
                o_ctrl.PCWriteCond = 1'b1;
                o_ctrl.branch_ne   = (i_opcode == OP_BNE);
            end
            S_JUMP: begin
                o_ctrl.PCWrite  = 1'b1;
                o_ctrl.PCSource = PCSRC_JUMP;
            end
            S_ADDIEX: begin
                o_ctrl.ALUSrcA = 1'b1;
                o_ctrl.ALUSrcB = SRCB_SEXT;
            end
            S_ADDIWB: o_ctrl.RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer: state register, next-state logic, retire counter
// and final PC enable around a combinational control-word decode.
module multicycle_control
    import mc_pkg::*;
#(
    parameter int RETIRED_W = 32
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    multicycle_control_if.master bus
);

    logic [3:0]           r_state;
    logic                 r_run;
    logic [RETIRED_W-1:0] r_retired;
    logic [3:0]           w_next;
    logic                 w_retire;
    ctrl_t                w_ctrl;
    ctrl_t                w_out;

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (bus.opcode),
        .i_mem_ready (bus.mem_ready),
        .o_ctrl      (w_ctrl)
    );

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = S_EXEC;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_J:           w_next = S_JUMP;
                    OP_ADDI:        w_next = S_ADDIEX;
                    default:        w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_retire = 1'b0;
        if (r_run && w_next == S_FETCH) begin
            case (r_state)
                S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: w_retire = 1'b1;
                default: w_retire = 1'b0;
            endcase
        end
    end

    // r_run stays low until the first edge after reset release, so the FETCH
    // strobes are held off for that first partial cycle as well as during reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= S_FETCH;
            r_run     <= 1'b0;
            r_retired <= '0;
        end else begin
            r_run <= 1'b1;
            if (r_run) begin
                r_state <= w_next;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign w_out = r_run ? w_ctrl : '0;

    assign bus.PCWrite    = w_out.PCWrite;
    assign bus.pc_en      = w_out.PCWrite | (w_out.PCWriteCond & (bus.Zero ^ w_out.branch_ne));
    assign bus.IorD       = w_out.IorD;
    assign bus.MemRead    = w_out.MemRead;
    assign bus.MemWrite   = w_out.MemWrite;
    assign bus.IRWrite    = w_out.IRWrite;
    assign bus.MemtoReg   = w_out.MemtoReg;
    assign bus.RegDst     = w_out.RegDst;
    assign bus.RegWrite   = w_out.RegWrite;
    assign bus.ALUSrcA    = w_out.ALUSrcA;
    assign bus.ALUSrcB    = w_out.ALUSrcB;
    assign bus.ALUOp      = w_out.ALUOp;
    assign bus.PCSource   = w_out.PCSource;
    assign bus.illegal_op = w_out.illegal_op;
    assign bus.state_dbg  = r_state;
    assign bus.retired    = r_retired;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the
// sequencer and checks state, strobes, pc_en and the retire count against hand values.
module tb_multicycle_control;

    logic clk;
    logic rstN;
    int   assertCount;
    int   failCount;

    multicycle_control_if #(.RETIRED_W(32)) bus ();

    multicycle_control #(.RETIRED_W(32)) dut (
        .CLK     (clk),
        .RESET_N (rstN),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] op, input logic ready, input logic zero);
        bus.opcode    = op;
        bus.mem_ready = ready;
        bus.Zero      = zero;
        #1;
    endtask

    task automatic clockStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        rstN        = 1'b0;
        applyStimulus(6'd0, 1'b0, 1'b0);

        // Reset state and output gating up to the first edge after release.
        #2;
        checkOutput("rst_state", 32'(bus.state_dbg), 32'd0);
        checkOutput("rst_retired", bus.retired, 32'd0);
        checkOutput("rst_memread", 32'(bus.MemRead), 32'd0);
        repeat (2) clockStep();
        rstN = 1'b1;
        #1;
        checkOutput("prerun_memread", 32'(bus.MemRead), 32'd0);
        clockStep();
        checkOutput("fetch_memread", 32'(bus.MemRead), 32'd1);
        checkOutput("fetch_srcb", 32'(bus.ALUSrcB), 32'd1);
        checkOutput("fetch_irwrite_wait", 32'(bus.IRWrite), 32'd0);

        // R-type: 0,1,6,7,0
        applyStimulus(6'd0, 1'b1, 1'b0);
        checkOutput("r_irwrite", 32'(bus.IRWrite), 32'd1);
        checkOutput("r_pcen_fetch", 32'(bus.pc_en), 32'd1);
        clockStep();
        applyStimulus(6'd0, 1'b0, 1'b0);
        checkOutput("r_decode", 32'(bus.state_dbg), 32'd1);
        checkOutput("r_decode_srcb", 32'(bus.ALUSrcB), 32'd3);
        clockStep();
        checkOutput("r_exec", 32'(bus.state_dbg), 32'd6);
        checkOutput("r_exec_aluop", 32'(bus.ALUOp), 32'd2);
        clockStep();
        checkOutput("r_aluwb", 32'(bus.state_dbg), 32'd7);
        checkOutput("r_regwrite", 32'(bus.RegWrite), 32'd1);
        checkOutput("r_regdst", 32'(bus.RegDst), 32'd1);
        clockStep();
        checkOutput("r_fetch", 32'(bus.state_dbg), 32'd0);
        checkOutput("r_retired", bus.retired, 32'd1);

        // lw with three wait cycles in MEMRD
        applyStimulus(6'd35, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd35, 1'b0, 1'b0);
        clockStep();
        checkOutput("lw_memadr", 32'(bus.state_dbg), 32'd2);
        checkOutput("lw_memadr_srcb", 32'(bus.ALUSrcB), 32'd2);
        clockStep();
        for (int i = 0; i < 4; i++) begin
            checkOutput("lw_memrd", 32'(bus.state_dbg), 32'd3);
            checkOutput("lw_memrd_rd", 32'(bus.MemRead), 32'd1);
            checkOutput("lw_memrd_iord", 32'(bus.IorD), 32'd1);
            if (i == 3) applyStimulus(6'd35, 1'b1, 1'b0);
            clockStep();
        end
        applyStimulus(6'd35, 1'b0, 1'b0);
        checkOutput("lw_memwb", 32'(bus.state_dbg), 32'd4);
        checkOutput("lw_memtoreg", 32'(bus.MemtoReg), 32'd1);
        clockStep();
        checkOutput("lw_fetch", 32'(bus.state_dbg), 32'd0);
        checkOutput("lw_retired", bus.retired, 32'd2);

        // Branch polarity: beq Z=1, bne Z=1, bne Z=0
        applyStimulus(6'd4, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd4, 1'b0, 1'b1);
        clockStep();
        checkOutput("beq_state", 32'(bus.state_dbg), 32'd8);
        checkOutput("beq_pcen", 32'(bus.pc_en), 32'd1);
        checkOutput("beq_pcsrc", 32'(bus.PCSource), 32'd1);
        checkOutput("beq_aluop", 32'(bus.ALUOp), 32'd1);
        clockStep();
        checkOutput("beq_retired", bus.retired, 32'd3);

        applyStimulus(6'd5, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd5, 1'b0, 1'b1);
        clockStep();
        checkOutput("bne_z1_pcen", 32'(bus.pc_en), 32'd0);
        clockStep();
        checkOutput("bne_z1_retired", bus.retired, 32'd4);

        applyStimulus(6'd5, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd5, 1'b0, 1'b0);
        clockStep();
        checkOutput("bne_z0_pcen", 32'(bus.pc_en), 32'd1);
        clockStep();
        checkOutput("bne_z0_retired", bus.retired, 32'd5);

        // Illegal opcode
        applyStimulus(6'h3F, 1'b1, 1'b0);
        checkOutput("ill_fetch_flag", 32'(bus.illegal_op), 32'd0);
        clockStep();
        applyStimulus(6'h3F, 1'b0, 1'b0);
        checkOutput("ill_decode", 32'(bus.state_dbg), 32'd1);
        checkOutput("ill_flag", 32'(bus.illegal_op), 32'd1);
        clockStep();
        checkOutput("ill_next", 32'(bus.state_dbg), 32'd0);
        checkOutput("ill_flag_gone", 32'(bus.illegal_op), 32'd0);
        checkOutput("ill_retired", bus.retired, 32'd5);

        // sw, then asynchronous reset while waiting in MEMWR
        applyStimulus(6'd43, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd43, 1'b0, 1'b0);
        clockStep();
        clockStep();
        checkOutput("sw_memwr", 32'(bus.state_dbg), 32'd5);
        checkOutput("sw_memwrite", 32'(bus.MemWrite), 32'd1);
        clockStep();
        checkOutput("sw_memwrite_hold", 32'(bus.MemWrite), 32'd1);
        checkOutput("sw_iord", 32'(bus.IorD), 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst_memwrite", 32'(bus.MemWrite), 32'd0);
        checkOutput("arst_state", 32'(bus.state_dbg), 32'd0);
        checkOutput("arst_retired", bus.retired, 32'd0);
        clockStep();
        rstN = 1'b1;
        #1;
        checkOutput("rel_memread_pre", 32'(bus.MemRead), 32'd0);
        clockStep();
        checkOutput("rel_state", 32'(bus.state_dbg), 32'd0);
        checkOutput("rel_memread", 32'(bus.MemRead), 32'd1);

        // Jump then addi
        applyStimulus(6'd2, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd2, 1'b0, 1'b0);
        clockStep();
        checkOutput("j_state", 32'(bus.state_dbg), 32'd9);
        checkOutput("j_pcwrite", 32'(bus.PCWrite), 32'd1);
        checkOutput("j_pcsrc", 32'(bus.PCSource), 32'd2);
        checkOutput("j_pcen", 32'(bus.pc_en), 32'd1);
        clockStep();
        checkOutput("j_retired", bus.retired, 32'd1);

        applyStimulus(6'd8, 1'b1, 1'b0);
        clockStep();
        applyStimulus(6'd8, 1'b0, 1'b0);
        checkOutput("addi_decode", 32'(bus.state_dbg), 32'd1);
        clockStep();
        checkOutput("addi_ex", 32'(bus.state_dbg), 32'd10);
        checkOutput("addi_srcb", 32'(bus.ALUSrcB), 32'd2);
        checkOutput("addi_srca", 32'(bus.ALUSrcA), 32'd1);
        clockStep();
        checkOutput("addi_wb", 32'(bus.state_dbg), 32'd11);
        checkOutput("addi_regwrite", 32'(bus.RegWrite), 32'd1);
        checkOutput("addi_regdst", 32'(bus.RegDst), 32'd0);
        clockStep();
        checkOutput("addi_fetch", 32'(bus.state_dbg), 32'd0);
        checkOutput("addi_retired", bus.retired, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
